// File: rtl/sensor_input_conditioner_pkg.sv
// ----------------------------------------------------------------------------
// Package: sensor_input_conditioner_pkg
// Purpose: Shared types and default constants for the sensor input
//          conditioner. It holds the per-channel hysteresis FSM state encoding,
//          the default thresholds, and a helper that maps a state to the
//          conditioned logic level.
// ----------------------------------------------------------------------------
package sensor_input_conditioner_pkg;

  // Per-channel hysteresis state. The encodings are fixed so that waveforms
  // match the rest of the codebase.
  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_RISE = 2'd1,
    ST_HIGH = 2'd2,
    ST_FALL = 2'd3
  } chan_state_e;

  // Default conditioning constants for an 8-bit inducer sample.
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TH_HI   = 160;
  localparam int DEF_TH_LO   = 96;
  localparam int DEF_PERSIST = 3;
  localparam int DEF_CNT_W   = 2;

  // The level is high while the channel sits in HIGH, and also while it is
  // still confirming a fall (FALL). It is low in LOW and in RISE.
  function automatic logic state_level(input chan_state_e st);
    return (st == ST_HIGH) || (st == ST_FALL);
  endfunction

endpackage : sensor_input_conditioner_pkg

// File: rtl/sensor_input_conditioner_hysteresis_channel.sv
// ----------------------------------------------------------------------------
// Module: hysteresis_channel
// Purpose: Conditions one sensor channel. Two thresholds provide hysteresis,
//          and a persistence counter means the level only switches after
//          PERSIST consecutive qualifying valid samples. Idle cycles hold all
//          state.
// Ports:
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset
//   sample_valid  in   sample holds a new reading this cycle
//   sample        in   [WIDTH-1:0] unsigned sensor reading
//   level         out  registered conditioned level
//   level_next    out  level that will be registered on the coming edge
//                      (used by the parent for same-edge change detection)
// ----------------------------------------------------------------------------
module hysteresis_channel
  import sensor_input_conditioner_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TH_HI   = DEF_TH_HI,
  parameter int TH_LO   = DEF_TH_LO,
  parameter int PERSIST = DEF_PERSIST,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  output logic             level,
  output logic             level_next
);

  localparam logic [WIDTH-1:0] TH_HI_V   = WIDTH'(TH_HI);
  localparam logic [WIDTH-1:0] TH_LO_V   = WIDTH'(TH_LO);
  // One bit wider than the counter, so cnt+1 compares against PERSIST without
  // wrapping.
  localparam logic [CNT_W:0]   PERSIST_V = (CNT_W + 1)'(PERSIST);

  chan_state_e      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W:0]   cnt_inc;
  logic             is_hi, is_lo;

  // Both boundaries are inclusive.
  assign is_hi   = (sample >= TH_HI_V);
  assign is_lo   = (sample <= TH_LO_V);
  assign cnt_inc = {1'b0, cnt} + 1'b1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next = state;
    cnt_next   = cnt;
    if (sample_valid) begin
      unique case (state)
        ST_LOW: begin
          if (is_hi) begin
            if (PERSIST == 1) begin
              state_next = ST_HIGH;
              cnt_next   = '0;
            end else begin
              state_next = ST_RISE;
              cnt_next   = CNT_W'(1);
            end
          end
        end
        ST_RISE: begin
          if (is_hi) begin
            if (cnt_inc == PERSIST_V) begin
              state_next = ST_HIGH;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_inc[CNT_W-1:0];
            end
          end else begin
            // Anything below TH_HI, including the dead band, aborts the rise.
            state_next = ST_LOW;
            cnt_next   = '0;
          end
        end
        ST_HIGH: begin
          if (is_lo) begin
            if (PERSIST == 1) begin
              state_next = ST_LOW;
              cnt_next   = '0;
            end else begin
              state_next = ST_FALL;
              cnt_next   = CNT_W'(1);
            end
          end
        end
        ST_FALL: begin
          if (is_lo) begin
            if (cnt_inc == PERSIST_V) begin
              state_next = ST_LOW;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_inc[CNT_W-1:0];
            end
          end else begin
            state_next = ST_HIGH;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = ST_LOW;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign level_next = state_level(state_next);

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments, so every register
    // in this block samples values from before the edge.
    if (rst) begin
      state <= ST_LOW;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      level <= level_next;
    end
  end

endmodule : hysteresis_channel

// File: rtl/sensor_input_conditioner.sv
// ----------------------------------------------------------------------------
// Module: sensor_input_conditioner
// Purpose: Turns raw sampled sensor levels on two channels into clean in_A /
//          in_B logic levels for the combinational gate block. Each channel
//          applies hysteresis and a persistence filter. This top level adds a
//          registered one-cycle change pulse.
// Ports:
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset
//   sample_valid  in   sample_A/sample_B hold a new sample this cycle
//   sample_A      in   [WIDTH-1:0] channel A reading, unsigned
//   sample_B      in   [WIDTH-1:0] channel B reading, unsigned
//   in_A          out  conditioned level A, registered
//   in_B          out  conditioned level B, registered
//   change        out  one-cycle pulse on the edge where in_A or in_B toggles
// ----------------------------------------------------------------------------
module sensor_input_conditioner
  import sensor_input_conditioner_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TH_HI   = DEF_TH_HI,
  parameter int TH_LO   = DEF_TH_LO,
  parameter int PERSIST = DEF_PERSIST,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_A,
  input  logic [WIDTH-1:0] sample_B,
  output logic             in_A,
  output logic             in_B,
  output logic             change
);

  // Parameter legality is checked at elaboration time, so a bad configuration
  // never produces hardware.
  if (TH_LO >= TH_HI) begin : g_bad_thresholds
    $fatal(1, "sensor_input_conditioner: TH_LO (%0d) must be below TH_HI (%0d)",
           TH_LO, TH_HI);
  end
  if (PERSIST < 1) begin : g_bad_persist
    $fatal(1, "sensor_input_conditioner: PERSIST (%0d) must be >= 1", PERSIST);
  end
  if (((1 << CNT_W) - 1) < PERSIST) begin : g_bad_cnt_w
    $fatal(1, "sensor_input_conditioner: CNT_W (%0d) too small for PERSIST (%0d)",
           CNT_W, PERSIST);
  end

  logic a_next, b_next;

  hysteresis_channel #(
    .WIDTH  (WIDTH),
    .TH_HI  (TH_HI),
    .TH_LO  (TH_LO),
    .PERSIST(PERSIST),
    .CNT_W  (CNT_W)
  ) u_chan_a (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample      (sample_A),
    .level       (in_A),
    .level_next  (a_next)
  );

  hysteresis_channel #(
    .WIDTH  (WIDTH),
    .TH_HI  (TH_HI),
    .TH_LO  (TH_LO),
    .PERSIST(PERSIST),
    .CNT_W  (CNT_W)
  ) u_chan_b (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample      (sample_B),
    .level       (in_B),
    .level_next  (b_next)
  );

  // The pulse is computed from the next levels, so it registers on the same
  // edge as the toggle. Simultaneous A/B toggles merge into one pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      change <= 1'b0;
    end else begin
      change <= (a_next ^ in_A) | (b_next ^ in_B);
    end
  end

endmodule : sensor_input_conditioner

// File: tb/tb_sensor_input_conditioner.sv
// ----------------------------------------------------------------------------
// Testbench: tb_sensor_input_conditioner
// Runs directed vectors with literal expectations, then a short pseudo-random
// section near the thresholds. A run-length model checks the outputs after
// every clock edge.
// ----------------------------------------------------------------------------
module tb_sensor_input_conditioner;

  localparam int WIDTH   = 8;
  localparam int TH_HI   = 160;
  localparam int TH_LO   = 96;
  localparam int PERSIST = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sample_valid = 1'b0;
  logic [WIDTH-1:0] sample_A = '0;
  logic [WIDTH-1:0] sample_B = '0;
  logic             in_A, in_B, change;

  int total = 0;
  int bad   = 0;

  sensor_input_conditioner #(
    .WIDTH  (WIDTH),
    .TH_HI  (TH_HI),
    .TH_LO  (TH_LO),
    .PERSIST(PERSIST),
    .CNT_W  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample_A    (sample_A),
    .sample_B    (sample_B),
    .in_A        (in_A),
    .in_B        (in_B),
    .change      (change)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic actual, input logic expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: each channel holds a level and the length of the current run of
  // consecutive valid samples that point to the opposite level.
  bit m_lvl [2];
  int m_run [2];
  bit m_chg;

  function automatic void model_chan(int ch, int s);
    bit toward;
    if (m_lvl[ch] == 1'b0) toward = (s >= TH_HI);
    else                   toward = (s <= TH_LO);
    if (toward) m_run[ch]++;
    else        m_run[ch] = 0;
    if (m_run[ch] == PERSIST) begin
      m_lvl[ch] = !m_lvl[ch];
      m_run[ch] = 0;
    end
  endfunction

  initial begin : compare_proc
    bit pa, pb;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_lvl = '{0, 0};
        m_run = '{0, 0};
        m_chg = 1'b0;
      end else begin
        pa = m_lvl[0];
        pb = m_lvl[1];
        if (sample_valid) begin
          model_chan(0, int'(sample_A));
          model_chan(1, int'(sample_B));
        end
        m_chg = (pa != m_lvl[0]) || (pb != m_lvl[1]);
      end
      @(negedge clk);
      check("model in_A", in_A, m_lvl[0]);
      check("model in_B", in_B, m_lvl[1]);
      check("model change", change, m_chg);
    end
  end

  // One clock: apply the inputs, then return at the next falling edge.
  task automatic step(input logic r, input logic v, input int a, input int b);
    rst          = r;
    sample_valid = v;
    sample_A     = WIDTH'(a);
    sample_B     = WIDTH'(b);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic repeat_a(input int n, input int a);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, a, 0);
  endtask

  initial begin : stimulus
    @(negedge clk);

    // Reset wins over valid high samples.
    step(1'b1, 1'b1, 255, 255);
    step(1'b1, 1'b1, 255, 255);
    check("reset in_A", in_A, 1'b0);
    check("reset in_B", in_B, 1'b0);
    check("reset change", change, 1'b0);

    // Rise after three samples; the change pulse lasts one cycle.
    step(1'b0, 1'b1, 200, 0);
    check("rise 1 in_A", in_A, 1'b0);
    step(1'b0, 1'b1, 200, 0);
    check("rise 2 in_A", in_A, 1'b0);
    step(1'b0, 1'b1, 200, 0);
    check("rise 3 in_A", in_A, 1'b1);
    check("rise 3 change", change, 1'b1);
    step(1'b0, 1'b0, 0, 0);
    check("rise idle change", change, 1'b0);
    check("rise idle in_A", in_A, 1'b1);

    // Return to low, then a dead-band sample aborts the pending rise.
    repeat_a(3, 50);
    check("fall in_A", in_A, 1'b0);
    repeat_a(2, 200);
    repeat_a(1, 120);
    repeat_a(2, 200);
    check("abort in_A", in_A, 1'b0);
    repeat_a(1, 200);
    check("abort 3rd in_A", in_A, 1'b1);

    // Hysteresis and inclusive boundaries.
    repeat_a(5, 97);
    check("hyst 97 in_A", in_A, 1'b1);
    repeat_a(2, 96);
    check("hyst 96x2 in_A", in_A, 1'b1);
    repeat_a(1, 96);
    check("hyst 96x3 in_A", in_A, 1'b0);
    repeat_a(3, 160);
    check("hyst 160x3 in_A", in_A, 1'b1);
    repeat_a(3, 0);
    check("low again in_A", in_A, 1'b0);

    // Idle gaps do not break a run; both channels rise on one edge.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 200, 200);
      if (k < 2) begin
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
      end
    end
    check("gap in_A", in_A, 1'b1);
    check("gap in_B", in_B, 1'b1);
    check("gap change", change, 1'b1);
    step(1'b0, 1'b0, 0, 0);
    check("gap change drop", change, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 0, 200);
    check("A-only in_A", in_A, 1'b0);
    check("A-only in_B", in_B, 1'b1);

    // A reset in the middle of a run discards the count.
    repeat_a(2, 200);
    step(1'b1, 1'b1, 200, 0);
    check("mid reset in_B", in_B, 1'b0);
    repeat_a(2, 200);
    check("post reset 2 in_A", in_A, 1'b0);
    repeat_a(1, 200);
    check("post reset 3 in_A", in_A, 1'b1);

    // Pseudo-random samples clustered around both thresholds.
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'($urandom_range(0, 3) != 0),
           int'($urandom_range(80, 180)), int'($urandom_range(80, 180)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sensor_input_conditioner
